ps2_frame_rx: RTL and testbench



---
 rtl/ps2_frame_rx_pkg.sv | 20 ++
 rtl/ps2_frame_rx_if.sv | 24 ++
 rtl/ps2_frame_rx_line_filter.sv | 50 +++++
 rtl/ps2_frame_rx.sv | 137 +++++++++++++
 tb/tb_ps2_frame_rx.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_frame_rx_pkg.sv
// Shared types and constants for the PS/2 device-to-host frame receiver.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'b00;
  localparam err_code_t ERR_PARITY  = 2'b01;
  localparam err_code_t ERR_FRAME   = 2'b10;
  localparam err_code_t ERR_TIMEOUT = 2'b11;

  localparam int DATA_BITS = 8;

  // PS/2 uses odd parity over the data byte plus the parity bit.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// Pin and byte-stream bundle between the PS/2 receiver and its neighbours.
interface ps2_frame_rx_if;
  import ps2_pkg::*;

  logic       ena;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  err_code_t  err_code;
  logic       busy;

  modport master (
    output ena, ps2_clk, ps2_data,
    input  rx_data, rx_valid, rx_err, err_code, busy
  );

  modport slave (
    input  ena, ps2_clk, ps2_data,
    output rx_data, rx_valid, rx_err, err_code, busy
  );

endinterface

// File: rtl/ps2_frame_rx_line_filter.sv
// Pin synchroniser followed by a stability filter; idles high out of reset.
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic line_o
);
  import ps2_pkg::*;

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // The filtered line only follows a deviation that lasts FILTER_LEN cycles.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
    filt_d = filt_q;
    cnt_d  = '0;
    if (synced != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host deserialiser: filtered pins in, checked bytes and error strobes out.
module ps2_frame_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input logic           clk,
  input logic           rst_n,
  ps2_frame_rx_if.slave bus
);
  import ps2_pkg::*;

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic clk_f, data_f, sample;

  state_t                 state_q, state_d;
  logic                   prev_clk_q, prev_clk_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_err_q, rx_err_d;
  err_code_t              err_code_q, err_code_d;
  logic                   busy;

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk(clk), .rst_n(rst_n), .line_i(bus.ps2_clk), .line_o(clk_f)
  );

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk(clk), .rst_n(rst_n), .line_i(bus.ps2_data), .line_o(data_f)
  );

  assign sample = prev_clk_q & ~clk_f;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A sample event outranks the timeout when both land in the same cycle.
  always_comb begin
    state_d    = state_q;
    prev_clk_d = clk_f;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    err_code_d = ERR_NONE;
    tmo_d      = (sample || state_q == IDLE) ? '0 : tmo_q + 1'b1;

    if (!bus.ena) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      tmo_d     = '0;
    end else if (sample) begin
      case (state_q)
        IDLE: begin
          if (!data_f) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {data_f, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_f;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!data_f) begin
            rx_err_d   = 1'b1;
            err_code_d = ERR_FRAME;
          end else if (!odd_parity_ok(shift_q, parity_q)) begin
            rx_err_d   = 1'b1;
            err_code_d = ERR_PARITY;
          end else begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TMO_LIMIT) begin
      state_d    = IDLE;
      rx_err_d   = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_clk_q <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      prev_clk_q <= prev_clk_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  assign bus.busy     = busy;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_err   = rx_err_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Scoreboard bench for ps2_frame_rx: frames are bit-banged on the pins, expected bytes/errors queued.
module tb_ps2_frame_rx;
  localparam int SYNC_STAGES    = 2;
  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 20000;
  localparam int HALF           = 40;

  typedef struct {
    logic       is_err;
    logic [1:0] code;
    logic [7:0] data;
    int         min_cyc;
    int         max_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   last_fall_cyc = 0;
  logic [7:0] last_good = 8'h00;
  logic prev_strobe = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  ps2_frame_rx_if bus_if();

  ps2_frame_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit cell; optional short clock glitches sit well inside the high phase.
  task automatic sendBit(input logic b, input bit glitch);
    bus_if.ps2_data = b;
    if (glitch) begin
      waitCycles(8);
      bus_if.ps2_clk = 1'b0;
      waitCycles(2);
      bus_if.ps2_clk = 1'b1;
      waitCycles(HALF / 2 - 10);
    end else begin
      waitCycles(HALF / 2);
    end
    bus_if.ps2_clk = 1'b0;
    last_fall_cyc  = cyc;
    waitCycles(HALF);
    bus_if.ps2_clk = 1'b1;
    waitCycles(HALF / 2);
  endtask

  task automatic waitDrain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) waitCycles(1);
    checkOutput("drain", exp_q.size(), 0);
    exp_q.delete();
    waitCycles(5);
    checkOutput("busy_idle", bus_if.busy, 1'b0);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stopb, input bit glitch);
    exp_t e;
    e.is_err  = !stopb || ((^d ^ par) != 1'b1);
    e.code    = !stopb ? 2'b10 : 2'b01;
    e.data    = d;
    e.min_cyc = 0;
    e.max_cyc = 0;
    exp_q.push_back(e);
    sendBit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) sendBit(d[i], glitch && (i == 2 || i == 5));
    sendBit(par, 1'b0);
    sendBit(stopb, 1'b0);
    bus_if.ps2_data = 1'b1;
    waitDrain(300);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rx_data"},  bus_if.rx_data, 8'h00);
    checkOutput({tag, "_rx_valid"}, bus_if.rx_valid, 1'b0);
    checkOutput({tag, "_rx_err"},   bus_if.rx_err, 1'b0);
    checkOutput({tag, "_err_code"}, bus_if.err_code, 2'b00);
    checkOutput({tag, "_busy"},     bus_if.busy, 1'b0);
  endtask

  // Start bit plus the low nibble of 0xF0; the remaining bits are all ones and get ignored in IDLE.
  task automatic sendPartialF0();
    sendBit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b0, 1'b0);
    checkOutput("busy_mid", bus_if.busy, 1'b1);
  endtask

  task automatic sendRestF0();
    for (int i = 0; i < 6; i++) sendBit(1'b1, 1'b0);
    waitCycles(20);
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus_if.rx_valid || bus_if.rx_err)) begin
      checkOutput("strobe_excl", {31'b0, bus_if.rx_valid & bus_if.rx_err}, 0);
      checkOutput("one_cycle", {31'b0, prev_strobe}, 0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_strobe", {30'b0, bus_if.rx_err, bus_if.rx_valid}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("kind_err", bus_if.rx_err, mon_e.is_err);
        if (mon_e.is_err) begin
          checkOutput("err_code", bus_if.err_code, mon_e.code);
          checkOutput("rx_data_held", bus_if.rx_data, last_good);
        end else begin
          checkOutput("rx_data", bus_if.rx_data, mon_e.data);
          last_good = mon_e.data;
        end
        if (mon_e.max_cyc > 0)
          checkOutput("tmo_window", (cyc >= mon_e.min_cyc && cyc <= mon_e.max_cyc), 1);
      end
    end
    prev_strobe = rst_n && (bus_if.rx_valid || bus_if.rx_err);
  end

  initial begin
    exp_t e;
    bus_if.ena      = 1'b1;
    bus_if.ps2_clk  = 1'b1;
    bus_if.ps2_data = 1'b1;
    rst_n = 1'b0;
    waitCycles(3);
    checkResetValues("reset");
    rst_n = 1'b1;
    waitCycles(10);

    $display("[TB] good frames");
    applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0);

    $display("[TB] parity and framing errors");
    applyStimulus(8'h1C, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'hF0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0, 1'b0);

    $display("[TB] inactivity timeout");
    sendBit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) sendBit(((8'h5A >> i) & 8'h01) != 0, 1'b0);
    bus_if.ps2_data = 1'b1;
    e.is_err  = 1'b1;
    e.code    = 2'b11;
    e.data    = 8'h00;
    e.min_cyc = last_fall_cyc + TIMEOUT_CYCLES + 4;
    e.max_cyc = last_fall_cyc + TIMEOUT_CYCLES + 10;
    exp_q.push_back(e);
    waitDrain(TIMEOUT_CYCLES + 300);
    applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0);

    $display("[TB] glitch rejection");
    applyStimulus(8'h1C, 1'b0, 1'b1, 1'b1);

    $display("[TB] reset mid-frame");
    sendPartialF0();
    rst_n = 1'b0;
    waitCycles(1);
    checkResetValues("midrst");
    rst_n = 1'b1;
    last_good = 8'h00;
    sendRestF0();
    checkOutput("rst_busy_after", bus_if.busy, 1'b0);
    applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0);

    $display("[TB] enable drop mid-frame");
    sendPartialF0();
    bus_if.ena = 1'b0;
    waitCycles(1);
    checkOutput("ena_busy", bus_if.busy, 1'b0);
    bus_if.ena = 1'b1;
    sendRestF0();
    checkOutput("ena_busy_after", bus_if.busy, 1'b0);
    checkOutput("ena_rx_data", bus_if.rx_data, 8'h5A);
    applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
